// File: rtl/flash_qspi_reader.sv
// flash_qspi_reader: reads one 32-bit word from a QSPI NOR flash using the
// Quad I/O Fast Read command (0xEB), 24-bit address, mode byte 0xFF,
// 4 dummy clocks and 8 data nibbles. sck runs at HCLK/2.
//
// Ports:
//   HCLK, HRESETn  clock (rising edge) / asynchronous active-low reset
//   req, addr      word-read request (sampled while busy=0) and byte address
//   busy, done     transaction in flight / one-cycle completion pulse
//   rdata          read word, byte at addr in [7:0], held until next done
//   sck, ce_n      flash serial clock / chip enable (active low)
//   din            flash IO inputs
//   dout, douten   flash IO outputs and per-bit output enables
//
// Optional feature: define FR_SEQ_READ_EN to keep the flash selected after a
// read and continue straight into the data phase when the next request hits
// the following word address.
module flash_qspi_reader #(
  localparam int unsigned AW = 24,
  localparam int unsigned DW = 32,
  localparam int unsigned NW = 4,
  localparam int unsigned CW = 5
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          req,
  input  logic [AW-1:0] addr,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic          sck,
  output logic          ce_n,
  input  logic [NW-1:0] din,
  output logic [NW-1:0] dout,
  output logic [NW-1:0] douten
);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, MODE, DUMMY, DATA, DONE
`ifdef FR_SEQ_READ_EN
    , CEH
`endif
  } state_t;

  localparam logic [7:0]    QIO_CMD   = 8'hEB;
  localparam logic [CW-1:0] CNT_CMD   = 5'd7;
  localparam logic [CW-1:0] CNT_ADDR  = 5'd5;
  localparam logic [CW-1:0] CNT_MODE  = 5'd1;
  localparam logic [CW-1:0] CNT_DUMMY = 5'd3;
  localparam logic [CW-1:0] CNT_DATA  = 5'd7;
`ifdef FR_SEQ_READ_EN
  localparam logic [CW-1:0] CNT_CEH   = 5'd1;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;     // remaining SCKs (or CEH cycles) in phase
  logic          half_q, half_d;   // 0: next edge drives sck=0 half, 1: sck=1 half
  logic          smp_q, smp_d;     // din to be captured at this edge
  logic [AW-1:0] a_q, a_d;
  logic [DW-1:0] sh_q, sh_d, sh_in;
  logic [AW-1:0] addr_al;
  logic          accept;
  logic          busy_d, done_d, sck_d, ce_n_d;
  logic [DW-1:0] rdata_d;
  logic [NW-1:0] dout_d, douten_d;
`ifdef FR_SEQ_READ_EN
  logic          cont_q, cont_d;   // flash still selected in continuous-read mode
  logic [AW-1:0] nxt_q, nxt_d;     // address that continues the open read
`endif

  assign addr_al = addr & {{(AW-2){1'b1}}, 2'b00};
  assign accept  = (state_q == IDLE) && !busy && req;
  assign sh_in   = smp_q ? {sh_q[DW-NW-1:0], din} : sh_q;

  // State register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      half_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
    end
  end

  // Next-state: each phase counts whole SCK periods down to zero
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef FR_SEQ_READ_EN
          if (cont_q && addr_al == nxt_q) begin
            state_d = DATA;
            cnt_d   = CNT_DATA;
          end else if (cont_q) begin
            state_d = CEH;
            cnt_d   = CNT_CEH;
          end else begin
            state_d = CMD;
            cnt_d   = CNT_CMD;
          end
`else
          state_d = CMD;
          cnt_d   = CNT_CMD;
`endif
        end
      end
`ifdef FR_SEQ_READ_EN
      CEH: begin
        if (cnt_q == '0) begin
          state_d = CMD;
          cnt_d   = CNT_CMD;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
`endif
      CMD, ADDR, MODE, DUMMY, DATA: begin
        half_d = ~half_q;
        if (half_q) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 5'd1;
          end else begin
            case (state_q)
              CMD:     begin state_d = ADDR;  cnt_d = CNT_ADDR;  end
              ADDR:    begin state_d = MODE;  cnt_d = CNT_MODE;  end
              MODE:    begin state_d = DUMMY; cnt_d = CNT_DUMMY; end
              DUMMY:   begin state_d = DATA;  cnt_d = CNT_DATA;  end
              default: begin state_d = DONE;  cnt_d = '0;        end
            endcase
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    ce_n_d   = ce_n;
    sck_d    = sck;
    dout_d   = dout;
    douten_d = douten;
    busy_d   = busy;
    done_d   = 1'b0;
    rdata_d  = rdata;
    a_d      = a_q;
    sh_d     = sh_in;
    smp_d    = 1'b0;
`ifdef FR_SEQ_READ_EN
    cont_d   = cont_q;
    nxt_d    = nxt_q;
`endif
    case (state_q)
      IDLE: begin
        sck_d  = 1'b0;
        busy_d = accept;
        if (accept) begin
          a_d = addr_al;
`ifdef FR_SEQ_READ_EN
          cont_d = 1'b0;
`endif
        end
      end
`ifdef FR_SEQ_READ_EN
      CEH: begin
        ce_n_d   = 1'b1;
        sck_d    = 1'b0;
        dout_d   = '0;
        douten_d = '0;
      end
`endif
      CMD, ADDR, MODE, DUMMY, DATA: begin
        if (!half_q) begin
          // Falling half: present the next output bit/nibble
          ce_n_d = 1'b0;
          sck_d  = 1'b0;
          case (state_q)
            CMD: begin
              dout_d   = {3'b000, QIO_CMD[cnt_q[2:0]]};
              douten_d = 4'b0001;
            end
            ADDR: begin
              dout_d   = NW'(a_q >> {cnt_q[2:0], 2'b00});
              douten_d = 4'b1111;
            end
            MODE: begin
              dout_d   = 4'hF;
              douten_d = 4'b1111;
            end
            default: begin
              dout_d   = '0;
              douten_d = '0;
            end
          endcase
        end else begin
          sck_d = 1'b1;
          smp_d = (state_q == DATA);
        end
      end
      DONE: begin
        sck_d    = 1'b0;
        done_d   = 1'b1;
        dout_d   = '0;
        douten_d = '0;
        // Nibbles arrive byte0-high first; swap so addr lands in [7:0]
        rdata_d  = {sh_in[7:0], sh_in[15:8], sh_in[23:16], sh_in[31:24]};
`ifdef FR_SEQ_READ_EN
        cont_d   = 1'b1;
        nxt_d    = AW'(a_q + 24'd4);
`else
        ce_n_d   = 1'b1;
`endif
      end
      default: begin
        ce_n_d   = 1'b1;
        sck_d    = 1'b0;
        douten_d = '0;
      end
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ce_n   <= 1'b1;
      sck    <= 1'b0;
      dout   <= '0;
      douten <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      rdata  <= '0;
      a_q    <= '0;
      sh_q   <= '0;
      smp_q  <= 1'b0;
`ifdef FR_SEQ_READ_EN
      cont_q <= 1'b0;
      nxt_q  <= '0;
`endif
    end else begin
      ce_n   <= ce_n_d;
      sck    <= sck_d;
      dout   <= dout_d;
      douten <= douten_d;
      busy   <= busy_d;
      done   <= done_d;
      rdata  <= rdata_d;
      a_q    <= a_d;
      sh_q   <= sh_d;
      smp_q  <= smp_d;
`ifdef FR_SEQ_READ_EN
      cont_q <= cont_d;
      nxt_q  <= nxt_d;
`endif
    end
  end

endmodule

// File: tb/tb_flash_qspi_reader.sv
// Testbench for flash_qspi_reader: a behavioural QSPI flash that decodes the
// bus and serves bytes from a formula, plus a transaction-level model of the
// expected word, completion latency and chip-enable behaviour.
module tb_flash_qspi_reader;

`ifdef FR_SEQ_READ_EN
  localparam bit SEQ = 1'b1;
`else
  localparam bit SEQ = 1'b0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        req;
  logic [23:0] addr;
  logic        busy, done, sck, ce_n;
  logic [31:0] rdata;
  logic [3:0]  din = 4'h0;
  logic [3:0]  dout, douten;

  flash_qspi_reader dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .req(req), .addr(addr),
    .busy(busy), .done(done), .rdata(rdata), .sck(sck), .ce_n(ce_n),
    .din(din), .dout(dout), .douten(douten)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Flash contents: offset 0 of each word holds the word index, others a pattern
  logic [7:0] salt = 8'h00;
  function automatic logic [7:0] mem(input logic [23:0] a);
    logic [23:0] w;
    w = a >> 2;
    if (a[1:0] == 2'b00) return w[7:0];
    return 8'(16'h00AA + 16'h0011 * {8'd0, w[7:0]}) ^ salt;
  endfunction

  function automatic logic [31:0] ref_word(input logic [23:0] a);
    logic [23:0] b;
    b = {a[23:2], 2'b00};
    return {mem(24'(b + 24'd3)), mem(24'(b + 24'd2)), mem(24'(b + 24'd1)), mem(b)};
  endfunction

  // Transaction-level model state
  bit          cont = 1'b0;
  logic [23:0] exp_next = '0;

  function automatic int model_lat(input logic [23:0] a);
    if (SEQ && cont) return ({a[23:2], 2'b00} == exp_next) ? 17 : 59;
    return 57;
  endfunction

  // Behavioural QSPI flash, evaluated mid-cycle
  int          fn = 0;
  bit          psck = 1'b0;
  logic [7:0]  fcmd = '0, fmode = '0, lcmd = '0, lmode = '0;
  logic [23:0] fa = '0, lfa = '0;
  int          oe_bad = 0;
  int          sck_bad = 0;

  always @(negedge HCLK) begin : flash
    int         j;
    logic [7:0] b;
    if (ce_n) begin
      fn   = 0;
      psck = 1'b0;
    end else begin
      if (sck && !psck) begin
        if (fn < 8) begin
          fcmd = {fcmd[6:0], dout[0]};
          if (douten !== 4'b0001 || dout[3:1] !== 3'b000) oe_bad++;
        end else if (fn < 14) begin
          fa = {fa[19:0], dout};
          if (douten !== 4'b1111) oe_bad++;
        end else if (fn < 16) begin
          fmode = {fmode[3:0], dout};
          if (douten !== 4'b1111) oe_bad++;
          if (fn == 15) begin
            lcmd  = fcmd;
            lfa   = fa;
            lmode = fmode;
          end
        end else begin
          if (douten !== 4'b0000) oe_bad++;
          if (fn >= 20) begin
            j   = fn - 20;
            b   = mem(24'(fa + 24'(j / 2)));
            din = (j % 2 == 0) ? b[7:4] : b[3:0];
          end
        end
        fn++;
      end
      psck = sck;
    end
    if (ce_n && sck) sck_bad++;
  end

  // Shortest chip-deselect run between selections
  int run = 0;
  int min_run = 1000;
  bit seen_low = 1'b0;
  always @(negedge HCLK) begin
    if (ce_n) run++;
    else begin
      if (seen_low && run > 0 && run < min_run) min_run = run;
      run      = 0;
      seen_low = 1'b1;
    end
  end

  task automatic wait_ready();
    @(negedge HCLK);
    for (int k = 0; k < 200 && (busy !== 1'b0 || done !== 1'b0); k++) @(negedge HCLK);
  endtask

  task automatic do_read(input logic [23:0] a, input logic [31:0] exp_rd,
                         input int exp_lat, input string tag);
    int          t0, lat, ceh, bad0, exp_ceh;
    bit          got;
    logic [31:0] rd;
    wait_ready();
    bad0    = oe_bad;
    exp_ceh = (exp_lat == 17) ? 0 : (exp_lat == 59) ? 2 : 1;
    req  = 1'b1;
    addr = a;
    t0   = cyc + 1;
    @(posedge HCLK);
    @(negedge HCLK);
    req  = 1'b0;
    addr = 24'($urandom);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    got = 1'b0; lat = -1; ceh = 0; rd = 'x;
    for (int k = 0; k < 120; k++) begin
      if (done === 1'b1) begin
        got = 1'b1;
        lat = cyc - t0;
        rd  = rdata;
        break;
      end
      if (ce_n) ceh++;
      @(negedge HCLK);
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_ce_high_cycles"}, 32'(ceh), 32'(exp_ceh));
    check({tag, "_oe_phase"}, 32'(oe_bad - bad0), 32'd0);
    if (exp_lat != 17) begin
      check({tag, "_cmd"}, 32'(lcmd), 32'h0000_00EB);
      check({tag, "_flash_addr"}, 32'(lfa), 32'({a[23:2], 2'b00}));
      check({tag, "_mode"}, 32'(lmode), 32'h0000_00FF);
    end
    @(negedge HCLK);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    if (got) check({tag, "_rdata_hold"}, rdata, rd);
    cont     = SEQ;
    exp_next = 24'({a[23:2], 2'b00} + 24'd4);
  endtask

  typedef struct {
    logic [23:0] a;
    logic [31:0] rd;
    int          lat;
  } vec_t;

  vec_t tbl[6];
  int   ntbl;

  initial begin : main
    int          ndone, nacc, dbl, n;
    bit          pb, pd;
    logic [23:0] a;
    HRESETn = 1'b0;
    req     = 1'b0;
    addr    = '0;
    repeat (3) @(negedge HCLK);
    check("rst_ce_n", 32'(ce_n), 32'd1);
    check("rst_sck", 32'(sck), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_douten", 32'(douten), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    HRESETn = 1'b1;

    if (SEQ) begin
      tbl[0] = '{24'h000000, 32'hAAAAAA00, 57};
      tbl[1] = '{24'h000004, 32'hBBBBBB01, 17};
      tbl[2] = '{24'h000014, 32'hFFFFFF05, 59};
      tbl[3] = '{24'h000018, ref_word(24'h000018), 17};
      tbl[4] = '{24'hFFFFFC, ref_word(24'hFFFFFC), 59};
      tbl[5] = '{24'h000000, 32'hAAAAAA00, 17};
      ntbl = 6;
    end else begin
      tbl[0] = '{24'h000000, 32'hAAAAAA00, 57};
      tbl[1] = '{24'h000004, 32'hBBBBBB01, 57};
      tbl[2] = '{24'h00000C, 32'hDDDDDD03, 57};
      tbl[3] = '{24'hFFFFFC, ref_word(24'hFFFFFC), 57};
      tbl[4] = '{24'h000003, 32'hAAAAAA00, 57};
      ntbl = 5;
    end
    for (int i = 0; i < ntbl; i++)
      do_read(tbl[i].a, tbl[i].rd, tbl[i].lat, $sformatf("vec%0d", i));

    // req held high through busy: one done per accepted request
    wait_ready();
    req = 1'b1; addr = 24'h000040;
    ndone = 0; nacc = 0; dbl = 0; pb = busy; pd = done;
    for (int k = 0; k < 280; k++) begin
      @(negedge HCLK);
      if (k == 150) req = 1'b0;
      if (busy && !pb) nacc++;
      if (done && pd) dbl++;
      if (done) begin
        ndone++;
        check("hold_rdata", rdata, ref_word(24'h000040));
      end
      pb = busy; pd = done;
    end
    check("hold_done_vs_accept", 32'(ndone), 32'(nacc));
    check("hold_multi_done", 32'(ndone >= 2), 32'd1);
    check("hold_done_width", 32'(dbl), 32'd0);
    cont = SEQ; exp_next = 24'h000044;

    // Reset pulsed at edge 30 of a read
    wait_ready();
    req = 1'b1; addr = 24'h000020;
    n = cyc + 1;
    @(posedge HCLK);
    @(negedge HCLK);
    req = 1'b0;
    for (int k = 0; k < 60 && cyc < n + 30; k++) @(negedge HCLK);
    #2 HRESETn = 1'b0;
    #1;
    check("arst_ce_n", 32'(ce_n), 32'd1);
    check("arst_douten", 32'(douten), 32'd0);
    check("arst_sck", 32'(sck), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    cont = 1'b0;
    ndone = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge HCLK);
      if (done) ndone++;
    end
    check("arst_no_done", 32'(ndone), 32'd0);
    check("arst_rdata", rdata, 32'd0);

    // Randomized reads against the model
    salt = 8'($urandom);
    for (int i = 0; i < 24; i++) begin
      if (i == 3) a = 24'hFFFFFC;
      else if ($urandom_range(0, 1) == 1) a = exp_next | 24'($urandom_range(0, 3));
      else a = 24'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge HCLK);
      do_read(a, ref_word(a), model_lat(a), $sformatf("rnd%0d", i));
    end

    check("sck_low_when_deselected", 32'(sck_bad), 32'd0);
    check("ce_n_min_high", 32'(min_run >= 2), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/flash_qspi_reader.md
FLASH_QSPI_READER -- requirements
Module: flash_qspi_reader

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, with ports named HCLK and HRESETn.
REQ-002 HCLK  in  1  system clock; all logic rising-edge.
REQ-003 HRESETn  in  1  asynchronous active-low reset.
REQ-004 req  in  1  word-read request, sampled only while busy=0.
REQ-005 addr  in  24  flash byte address; addr[1:0] ignored and treated as 0.
REQ-006 busy  out  1  high from the cycle after acceptance until done.
REQ-007 done  out  1  one-cycle pulse; rdata valid in that cycle.
REQ-008 rdata  out  32  read word; flash byte at addr in [7:0], addr+3 in [31:24]; held until next done.
REQ-009 sck  out  1  flash serial clock.
REQ-010 ce_n  out  1  flash chip enable, active low.
REQ-011 din  in  4  flash IO inputs.
REQ-012 dout  out  4  flash IO outputs.
REQ-013 douten  out  4  per-bit output enables, high = drive.

Function
REQ-014 SHALL issue Quad I/O Fast Read: command 0xEB, 24-bit address, mode byte 0xFF, 4 dummy SCK, then 8 data nibbles.
REQ-015 SHALL use sck = HCLK/2: each SCK period is one HCLK with sck=0 (outputs change), then one HCLK with sck=1.
REQ-016 SHALL sample din at the HCLK edge that ends each sck=1 half.
REQ-017 SHALL hold sck=0 whenever ce_n=1.
REQ-018 Command phase: 8 SCK, MSB first on dout[0], douten=4'b0001, dout[3:1]=0.
REQ-019 Address phase: 6 SCK, MSB nibble first on dout[3:0]; mode phase: 2 SCK of nibble 0xF; douten=4'b1111 in both.
REQ-020 Dummy and data phases: douten=4'b0000.
REQ-021 Data nibbles SHALL be high nibble first per byte and assembled little-endian per REQ-008.
REQ-022 FSM states: IDLE, CMD, ADDR, MODE, DUMMY, DATA, DONE, plus CEH when REQ-032 is compiled in.
REQ-023 Transitions: req accepted in IDLE at edge 0; ce_n falls at edge 1; 28 SCK occupy edges 1..56; DONE at edge 57 (done=1, busy=1).
REQ-024 DONE SHALL set ce_n=1 and return to IDLE at the next edge; ce_n SHALL stay high for at least 2 HCLK between transactions.
REQ-025 req while busy=1 SHALL be ignored, with no queuing.
REQ-026 A 5-bit bit/nibble counter SHALL reload at each phase entry and never wrap within a phase.

Reset
REQ-027 Reset values: ce_n=1, sck=0, dout=0, douten=0, done=0, busy=0, rdata=0, FSM=IDLE.
REQ-028 Reset asserted mid-transaction SHALL force ce_n=1, douten=0 and sck=0 immediately, without waiting for a clock edge.
REQ-029 A partial rdata SHALL NOT be presented after reset; no done pulse follows reset.

Configuration
REQ-030 Macro FR_SEQ_READ_EN SHALL select sequential-read continuation.
REQ-031 Without FR_SEQ_READ_EN, every transaction is the full 57-cycle sequence of REQ-023.
REQ-032 With FR_SEQ_READ_EN, after DONE: ce_n stays low, sck stays 0, the FSM waits in IDLE, and the next expected address (last+4, 24-bit wrap) is recorded.
REQ-033 With FR_SEQ_READ_EN, a req matching the expected address SHALL go directly to DATA: 8 SCK, done at edge 17.
REQ-034 With FR_SEQ_READ_EN, a non-matching req SHALL go through CEH (ce_n=1 for 2 HCLK), then perform the full sequence, with done at edge 59.
REQ-035 With FR_SEQ_READ_EN, address 0xFFFFFC followed by 0x000000 SHALL count as sequential.

Verification
REQ-036 Reset, then req with addr=0x000000 -> done at edge 57, rdata=0xAAAAAA00, 0xEB seen on dout[0] during edges 1..16.
REQ-037 With FR_SEQ_READ_EN off: addr 0x000004, then 0x00000C -> rdata 0xBBBBBB01, then 0xDDDDDD03; each done at 57; ce_n high for >=2 cycles between transactions.
REQ-038 With FR_SEQ_READ_EN on: 0x000000, then 0x000004 -> second done at edge 17, rdata=0xBBBBBB01, ce_n low throughout.
REQ-039 With FR_SEQ_READ_EN on: 0x000004, then 0x000014 -> CEH for 2 cycles, done at edge 59, rdata=0xFFFFFF05.
REQ-040 Reset pulsed at edge 30 of a read -> ce_n=1, douten=0 asynchronously; no done; rdata=0.
REQ-041 req held high during busy -> exactly one done per accepted req; douten checked against 0001/1111/0000 per phase.
